// File: rtl/pwm_from_counter.sv
// Purpose: registered PWM from an upstream free-running counter; duty updates are applied at the period boundary (count_in all-ones).
// Latency: pwm_out and period_done are registered, 1 cycle after count_in; a new duty takes effect from the count_in=0 after the boundary.
// Backpressure: one pending duty slot; duty_ready stays low from the cycle after a transfer until the cycle after the next boundary.
// Optional: define COUNT_SEQ_CHECK_EN to add a sticky seq_err flag that reports count_in not stepping by +1.
module pwm_from_counter #(
  parameter int               WIDTH      = 4,
  parameter int               PCW        = 8,
  parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_done,
  output logic [PCW-1:0]   period_cnt
`ifdef COUNT_SEQ_CHECK_EN
  ,
  output logic             seq_err
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active_duty;
  logic             boundary;
  logic             accept;

  // The last count of each period is the boundary; duty swaps happen there.
  assign boundary = (count_in == {WIDTH{1'b1}});
  assign accept   = duty_valid && duty_ready;

  // Pending-slot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Next state and duty_ready: the slot accepts only while empty, drains at a boundary.
  always_comb begin
    state_nxt  = state;
    duty_ready = 1'b0;
    case (state)
      EMPTY: begin
        duty_ready = 1'b1;
        // A transfer on the boundary cycle lands in the slot and waits a full period.
        if (duty_valid) state_nxt = FULL;
      end
      FULL: begin
        if (boundary) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Capture a requested duty, and promote it to the active duty at the boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      active_duty <= RESET_DUTY;
    end else begin
      if (accept)
        pending <= duty_in;
      if (state == FULL && boundary)
        active_duty <= pending;
    end
  end

  // Registered PWM compare plus period pulse and period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      period_cnt  <= '0;
    end else begin
      pwm_out     <= (count_in < active_duty);
      period_done <= boundary;
      if (boundary)
        period_cnt <= period_cnt + PCW'(1);
    end
  end

`ifdef COUNT_SEQ_CHECK_EN
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_valid;

  // Track the previous count and flag any step that is not +1 (mod 2^WIDTH); sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      prev_cnt   <= count_in;
      prev_valid <= 1'b1;
      if (prev_valid && (count_in != prev_cnt + WIDTH'(1)))
        seq_err <= 1'b1;
    end
  end
`endif

endmodule
